// File: rtl/frame_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_rr_sched_pkg
// Description : Shared constants, state encoding and helper function for the
//               frame round-robin scheduler and its 20x5 unloader.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_rr_sched_pkg;

    localparam int CHUNKS_PER_FRAME = 4;
    localparam int WORDS_PER_CHUNK  = 5;
    localparam int WORDS_PER_FRAME  = CHUNKS_PER_FRAME * WORDS_PER_CHUNK;

    // One bit is enough for the two states; the encoding is explicit so
    // that reset and decode values are unambiguous in netlists.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1, so an id field always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_unloader_20x5.sv
`default_nettype none
// ============================================================================
// Module      : frame_unloader_20x5
// Description : Holds one captured 20-word frame and emits it as four 5-word
//               chunks, least significant chunk first, with start/end marks.
// Ports       : clk, sclr      - clock, synchronous active-high reset
//               i_load         - capture i_frame this cycle (starts a frame)
//               i_frame        - 20-word frame to capture
//               i_ready        - downstream accept
//               o_data         - current chunk (low 5 words of storage)
//               o_valid        - chunk valid (frame in progress)
//               o_sop / o_eop  - first / last chunk of the frame
//               o_idle         - no frame in progress
//               o_last_fire    - final chunk is being accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module frame_unloader_20x5
    import frame_rr_sched_pkg::*;
#(
    parameter int WORD_LEN = 66
) (
    input  logic                                 clk,
    input  logic                                 sclr,
    input  logic                                 i_load,
    input  logic [WORDS_PER_FRAME*WORD_LEN-1:0]  i_frame,
    input  logic                                 i_ready,
    output logic [WORDS_PER_CHUNK*WORD_LEN-1:0]  o_data,
    output logic                                 o_valid,
    output logic                                 o_sop,
    output logic                                 o_eop,
    output logic                                 o_idle,
    output logic                                 o_last_fire
);

    localparam int CHUNK_W = WORDS_PER_CHUNK * WORD_LEN;
    localparam int FRAME_W = WORDS_PER_FRAME * WORD_LEN;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_beat;
    logic [FRAME_W-1:0]   r_storage;
    logic                 w_fire;
    logic                 w_last_fire;

    assign w_fire      = (r_state == SEND) & i_ready;
    assign w_last_fire = w_fire & (r_beat == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                // A load coinciding with the last chunk keeps us sending.
                if (w_last_fire) begin
                    w_state_nxt = i_load ? SEND : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state   <= IDLE;
            r_beat    <= 2'd0;
            r_storage <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_load) begin
                r_storage <= i_frame;
                r_beat    <= 2'd0;
            end else if (w_fire) begin
                // Zero fill leaves storage clear once the frame is drained,
                // so the data output idles at zero.
                r_storage <= r_storage >> CHUNK_W;
                r_beat    <= r_beat + 2'd1;
            end
        end
    end

    assign o_data      = r_storage[CHUNK_W-1:0];
    assign o_valid     = (r_state == SEND);
    assign o_sop       = (r_state == SEND) & (r_beat == 2'd0);
    assign o_eop       = (r_state == SEND) & (r_beat == 2'd3);
    assign o_idle      = (r_state == IDLE);
    assign o_last_fire = w_last_fire;

endmodule
`default_nettype wire

// File: rtl/frame_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_rr_scheduler
// Description : Round-robin scheduler sharing one 20-to-5 word unloader among
//               NUM_REQ requesters. Whole frames are granted atomically and
//               emitted as four tagged 5-word chunks.
// Config      : FRAME_RR_SCHED_B2B_EN - when defined, a new frame may be
//               granted in the cycle the previous frame's last chunk is
//               accepted (no bubble). Undefined: grants only when idle.
// Ports       : clk, sclr          - clock, synchronous active-high reset
//               req_din            - frame of requester i at slice i
//               req_valid          - per-requester frame valid
//               req_ready          - one-hot/zero accept (combinational)
//               dout, dout_valid   - current chunk and its valid
//               dout_ready         - downstream accept
//               dout_id            - source requester of current frame
//               dout_sop, dout_eop - first / last chunk markers
//               busy               - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rr_scheduler
    import frame_rr_sched_pkg::*;
#(
    parameter  int WORD_LEN = 66,
    parameter  int NUM_REQ  = 4,
    localparam int ID_W     = clog2_min1(NUM_REQ)
) (
    input  logic                                          clk,
    input  logic                                          sclr,
    input  logic [NUM_REQ*WORDS_PER_FRAME*WORD_LEN-1:0]   req_din,
    input  logic [NUM_REQ-1:0]                            req_valid,
    output logic [NUM_REQ-1:0]                            req_ready,
    output logic [WORDS_PER_CHUNK*WORD_LEN-1:0]           dout,
    output logic                                          dout_valid,
    input  logic                                          dout_ready,
    output logic [ID_W-1:0]                               dout_id,
    output logic                                          dout_sop,
    output logic                                          dout_eop,
    output logic                                          busy
);

    localparam int FRAME_W = WORDS_PER_FRAME * WORD_LEN;

    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_dout_id;
    logic [ID_W-1:0]    w_winner;
    logic               w_found;
    logic               w_window;
    logic               w_accept;
    logic               w_idle;
    logic               w_last_fire;
    logic               w_valid;
    logic [FRAME_W-1:0] w_frame;

    // Round-robin search starting one past the last accepted requester.
    // The sum is one bit wider than an id so the wrap needs no modulo.
    always_comb begin : p_arbiter
        logic [ID_W:0] w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = {1'b0, r_last_grant} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

`ifdef FRAME_RR_SCHED_B2B_EN
    assign w_window = w_idle | w_last_fire;
`else
    assign w_window = w_idle;
`endif

    assign w_accept = w_window & w_found & ~sclr;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign w_frame = req_din[w_winner*FRAME_W +: FRAME_W];

    always_ff @(posedge clk) begin
        if (sclr) begin
            // Pointer at the top index makes requester 0 the first winner.
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_dout_id    <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_winner;
            r_dout_id    <= w_winner;
        end
    end

    frame_unloader_20x5 #(
        .WORD_LEN (WORD_LEN)
    ) u_unloader (
        .clk         (clk),
        .sclr        (sclr),
        .i_load      (w_accept),
        .i_frame     (w_frame),
        .i_ready     (dout_ready),
        .o_data      (dout),
        .o_valid     (w_valid),
        .o_sop       (dout_sop),
        .o_eop       (dout_eop),
        .o_idle      (w_idle),
        .o_last_fire (w_last_fire)
    );

    assign dout_valid = w_valid;
    assign busy       = w_valid;
    assign dout_id    = r_dout_id;

endmodule
`default_nettype wire
